banked_main_mem: RTL and testbench
==================================

Name: banked_main_mem

Overview:
- Four-bank, fixed-latency word-addressed main memory.
- Sits directly downstream of the cache controller. It consumes the controller's mem_rd/mem_wr, address and write data during write-back and line-fill bursts, and returns read data and per-bank busy status.
- Successive words of a line go to different banks, so a 4-word burst streams at one request per cycle. A repeat access to a busy bank is stalled.

Parameters:
- ADDR_W, 16, byte address width. addr[0] is the byte offset, addr[2:1] selects the bank, addr[ADDR_W-1:3] is the row within the bank.
- DATA_W, 16, word width.
- BUSY_CYC, 4, cycles a bank stays busy after accepting a request (>=RD_LAT).
- RD_LAT, 2, cycles from read acceptance to data_out valid.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- addr  in  ADDR_W  byte address of request.
- data_in  in  DATA_W  write data.
- rd  in  1  read request.
- wr  in  1  write request.
- data_out  out  DATA_W  read data, valid only while rd_valid=1.
- rd_valid  out  1  one-cycle pulse marking returned read data.
- stall  out  1  combinational: request presented this cycle is not accepted.
- busy  out  4  per-bank busy flags, registered.
- err  out  1  combinational: illegal request presented.

Behaviour:
Reset (rst=0, asynchronous):
- data_out=0, rd_valid=0, busy=4'b0000, read pipeline emptied, busy counters=0.
- Storage array contents are not cleared.
- Reset asserted mid-operation discards in-flight reads; no rd_valid pulse follows.

Request legality:
- A request is present when rd|wr.
- err=1 when rd&wr, or when (rd|wr)&addr[0]. Such a request is ignored: no accept, no busy change, stall=0.
- stall = legal request & busy[addr[2:1]].

Accept at rising edge T (legal, not stalled):
- The target bank counter loads BUSY_CYC; busy[bank]=1 for cycles T+1..T+BUSY_CYC, then 0.
- Each counter decrements by 1 per cycle while nonzero.
- Write: the storage word is updated at edge T. It is readable by a request to that bank once the bank is free.
- Read: the word is read at edge T into stage 1 of a RD_LAT-deep valid/data shift pipeline. data_out/rd_valid are driven from the last stage, so data is valid during cycle T+RD_LAT for exactly one cycle.

Pipelining and ordering:
- Requests to distinct banks may be accepted on consecutive cycles.
- Read returns keep acceptance order, one per cycle, with no gaps for back-to-back reads.
- Write and read to different banks in the same burst are independent.

Boundary conditions:
- A bank becomes free exactly BUSY_CYC cycles after acceptance. A request at cycle T+BUSY_CYC is stalled; at T+BUSY_CYC+1 it is accepted.
- Stalled requests are not queued. The requester must hold rd/wr/addr/data_in until stall=0.
- Changing or dropping a stalled request has no side effect.
- Address wrap: the top row plus bank 3 is a normal location, with no special handling.

State per bank:
- IDLE (count=0) -> BUSY (count=BUSY_CYC) on accept.
- BUSY -> BUSY while count>1.
- BUSY -> IDLE when count reaches 0.
- Accept is impossible while in BUSY.
- Read pipeline stages are plain registers clocked every cycle, with valid cleared when no read was accepted.

Arithmetic:
- Counters are ceil(log2(BUSY_CYC+1)) bits wide.
- No other arithmetic is performed.

Test Plan:
1. Reset then idle: rst low 3 cycles, release -> busy=0000, rd_valid=0, data_out=0, stall=0, err=0.
2. Burst write/read: write 0x1111,0x2222,0x3333,0x4444 to 0x0100,0x0102,0x0104,0x0106 on 4 consecutive cycles -> no stall, busy walks 0001->0011->0111->1111. Wait 5 cycles, then read the same 4 addresses back-to-back -> rd_valid high 4 consecutive cycles starting 2 cycles after first read, with data 0x1111..0x4444 in order.
3. Bank conflict: read 0x0200 at T, read 0x0208 (same bank 0) at T+1 -> stall=1 for cycles T+1..T+4. Accepted at T+5; its data is valid at T+7.
4. Illegal requests: rd=wr=1 at 0x0010 -> err=1, stall=0, busy unchanged. Then wr at odd address 0x0011 -> err=1, memory unchanged (subsequent read of 0x0010 returns prior value).
5. Reset mid-read: read 0x0300 at T, assert rst at T+1 -> rd_valid never pulses, busy=0000 immediately. After release, read 0x0300 returns the previously written value.
6. Write-then-read same word: write 0xBEEF to 0x0400 at T, read 0x0400 presented at T+1 -> stall until T+4. Accepted at T+5, data_out=0xBEEF at T+7.

Source files
------------

// File: rtl/banked_main_mem.sv
// Four-bank word memory with fixed read latency and per-bank busy timers.
// Consecutive words go to different banks, so line bursts stream at one request per cycle.
module banked_main_mem #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int BUSY_CYC = 4,
  parameter int RD_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  input  logic              wr,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              stall,
  output logic [3:0]        busy,
  output logic              err
);

  localparam int CNT_W = $clog2(BUSY_CYC + 1);
  localparam int ROW_W = ADDR_W - 3;
  localparam int ROWS  = 1 << ROW_W;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BUSY_CYC);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [DATA_W-1:0] mem_r [4][ROWS];
  logic [CNT_W-1:0]  cnt_r [4];
  logic [CNT_W-1:0]  cnt_nxt_s [4];
  logic [3:0]        busy_r;
  logic [3:0]        busy_nxt_s;
  logic [RD_LAT-1:0] vld_r;
  logic [DATA_W-1:0] dat_r [RD_LAT];

  logic              req_s;
  logic              err_s;
  logic              legal_s;
  logic              stall_s;
  logic              acc_s;
  logic              rd_acc_s;
  logic              wr_acc_s;
  logic [1:0]        bank_s;
  logic [ROW_W-1:0]  row_s;
  logic [DATA_W-1:0] rd_word_s;

  // Request decode: legality, bank conflict and acceptance.
  always_comb begin
    req_s     = rd | wr;
    err_s     = (rd & wr) | (req_s & addr[0]);
    legal_s   = req_s & ~err_s;
    bank_s    = addr[2:1];
    row_s     = addr[ADDR_W-1:3];
    stall_s   = legal_s & busy_r[bank_s];
    acc_s     = legal_s & ~stall_s;
    rd_acc_s  = acc_s & rd;
    wr_acc_s  = acc_s & wr;
    rd_word_s = mem_r[bank_s][row_s];
  end

  // Next-state of the per-bank busy counters; an accept can only land on an idle bank.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    busy_nxt_s = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      if (acc_s && (bank_s == 2'(b))) begin
        cnt_nxt_s[b] = CNT_LOAD;
      end else if (cnt_r[b] != CNT_ZERO) begin
        cnt_nxt_s[b] = cnt_r[b] - CNT_W'(1);
      end else begin
        cnt_nxt_s[b] = cnt_r[b];
      end
      busy_nxt_s[b] = (cnt_nxt_s[b] != CNT_ZERO);
    end
  end

  // Busy counters and registered busy flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 4; b++) begin
        cnt_r[b] <= CNT_ZERO;
      end
      busy_r <= 4'b0000;
    end else begin
      cnt_r  <= cnt_nxt_s;
      busy_r <= busy_nxt_s;
    end
  end

  // Storage array; deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[bank_s][row_s] <= data_in;
    end
  end

  // Read return pipeline; idle slots carry zero data so data_out rests at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_r <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) begin
        dat_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      vld_r[0] <= rd_acc_s;
      dat_r[0] <= rd_acc_s ? rd_word_s : {DATA_W{1'b0}};
      for (int i = 1; i < RD_LAT; i++) begin
        vld_r[i] <= vld_r[i-1];
        dat_r[i] <= dat_r[i-1];
      end
    end
  end

  assign data_out = dat_r[RD_LAT-1];
  assign rd_valid = vld_r[RD_LAT-1];
  assign busy     = busy_r;
  assign stall    = stall_s;
  assign err      = err_s;

endmodule

// File: tb/tb_banked_main_mem.sv
// Directed bench for banked_main_mem: stimulus pushes expected read returns (data and cycle)
// into a scoreboard that a negedge monitor drains whenever rd_valid is seen.
module tb_banked_main_mem;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        rd;
  logic        wr;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  banked_main_mem dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .rd       (rd),
    .wr       (wr),
    .data_out (data_out),
    .rd_valid (rd_valid),
    .stall    (stall),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // cyc holds the index of the most recent rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every rd_valid pulse must match the oldest pending read in data and cycle
  always @(negedge clk) begin
    exp_t e;
    if (rd_valid) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL rd_unexpected: data_out=%h at cycle %0d, no read pending", data_out, cyc);
      end else begin
        e = sb_q.pop_front();
        if (data_out !== e.data || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL rd_return: got %h at cycle %0d, expected %h at cycle %0d",
                   data_out, cyc, e.data, e.cyc);
        end
      end
    end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL rd_missing: no rd_valid at cycle %0d, expected %h", e.cyc, e.data);
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Present one request for one cycle; starts and ends just after a rising edge
  task automatic req(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                     input logic exp_stall, input logic exp_err, input logic [3:0] exp_busy,
                     input logic [15:0] exp_rdata);
    rd = r;
    wr = w;
    addr = a;
    data_in = d;
    @(negedge clk);
    check("stall", 16'(stall), 16'(exp_stall));
    check("err", 16'(err), 16'(exp_err));
    check("busy", 16'(busy), 16'(exp_busy));
    @(posedge clk);
    #1;
    if (r && !w && !exp_stall && !exp_err) sb_q.push_back('{exp_rdata, cyc + RD_LAT - 1});
    rd = 1'b0;
    wr = 1'b0;
  endtask

  task automatic idle(input logic [3:0] exp_busy);
    rd = 1'b0;
    wr = 1'b0;
    @(negedge clk);
    check("busy_idle", 16'(busy), 16'(exp_busy));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(input int n);
    rd = 1'b0;
    wr = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    rd = 1'b0;
    wr = 1'b0;
    addr = 16'h0000;
    data_in = 16'h0000;

    // 1. reset then idle
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_busy", 16'(busy), 16'h0000);
    check("rst_rd_valid", 16'(rd_valid), 16'h0000);
    check("rst_data_out", data_out, 16'h0000);
    check("rst_stall", 16'(stall), 16'h0000);
    check("rst_err", 16'(err), 16'h0000);
    @(posedge clk);
    #1;

    // 2. burst write across the four banks, drain, burst read back
    req(1'b0, 1'b1, 16'h0100, 16'h1111, 1'b0, 1'b0, 4'b0000, 16'h0000);
    req(1'b0, 1'b1, 16'h0102, 16'h2222, 1'b0, 1'b0, 4'b0001, 16'h0000);
    req(1'b0, 1'b1, 16'h0104, 16'h3333, 1'b0, 1'b0, 4'b0011, 16'h0000);
    req(1'b0, 1'b1, 16'h0106, 16'h4444, 1'b0, 1'b0, 4'b0111, 16'h0000);
    idle(4'b1111);
    idle(4'b1110);
    idle(4'b1100);
    idle(4'b1000);
    idle(4'b0000);
    req(1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b0, 4'b0000, 16'h1111);
    req(1'b1, 1'b0, 16'h0102, 16'h0000, 1'b0, 1'b0, 4'b0001, 16'h2222);
    req(1'b1, 1'b0, 16'h0104, 16'h0000, 1'b0, 1'b0, 4'b0011, 16'h3333);
    req(1'b1, 1'b0, 16'h0106, 16'h0000, 1'b0, 1'b0, 4'b0111, 16'h4444);
    idle(4'b1111);
    idle_n(5);

    // 3. bank conflict, exercising the exact free boundary
    req(1'b0, 1'b1, 16'h0200, 16'hA5A5, 1'b0, 1'b0, 4'b0000, 16'h0000);
    idle_n(4);
    req(1'b0, 1'b1, 16'h0208, 16'h5A5A, 1'b0, 1'b0, 4'b0000, 16'h0000);
    idle_n(4);
    req(1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 1'b0, 4'b0000, 16'hA5A5);
    repeat (4) req(1'b1, 1'b0, 16'h0208, 16'h0000, 1'b1, 1'b0, 4'b0001, 16'h0000);
    req(1'b1, 1'b0, 16'h0208, 16'h0000, 1'b0, 1'b0, 4'b0000, 16'h5A5A);
    idle_n(5);

    // 4. illegal requests leave state and memory untouched
    req(1'b0, 1'b1, 16'h0010, 16'h1234, 1'b0, 1'b0, 4'b0000, 16'h0000);
    idle_n(4);
    req(1'b1, 1'b1, 16'h0010, 16'hFFFF, 1'b0, 1'b1, 4'b0000, 16'h0000);
    req(1'b0, 1'b1, 16'h0011, 16'hDEAD, 1'b0, 1'b1, 4'b0000, 16'h0000);
    req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 4'b0000, 16'h1234);
    idle_n(5);

    // 5. reset in the middle of a read discards it but keeps storage
    req(1'b0, 1'b1, 16'h0300, 16'h7777, 1'b0, 1'b0, 4'b0000, 16'h0000);
    idle_n(4);
    req(1'b1, 1'b0, 16'h0300, 16'h0000, 1'b0, 1'b0, 4'b0000, 16'h7777);
    rst = 1'b0;
    sb_q.delete();
    #1;
    check("midrst_busy", 16'(busy), 16'h0000);
    check("midrst_rd_valid", 16'(rd_valid), 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    req(1'b1, 1'b0, 16'h0300, 16'h0000, 1'b0, 1'b0, 4'b0000, 16'h7777);
    idle_n(5);

    // 6. write then read of the same word
    req(1'b0, 1'b1, 16'h0400, 16'hBEEF, 1'b0, 1'b0, 4'b0000, 16'h0000);
    repeat (4) req(1'b1, 1'b0, 16'h0400, 16'h0000, 1'b1, 1'b0, 4'b0001, 16'h0000);
    req(1'b1, 1'b0, 16'h0400, 16'h0000, 1'b0, 1'b0, 4'b0000, 16'hBEEF);
    idle_n(5);

    // top row of bank 3 is an ordinary location, distinct from row 0
    req(1'b0, 1'b1, 16'h0006, 16'h0606, 1'b0, 1'b0, 4'b0000, 16'h0000);
    idle_n(4);
    req(1'b0, 1'b1, 16'hFFFE, 16'hC0DE, 1'b0, 1'b0, 4'b0000, 16'h0000);
    idle_n(4);
    req(1'b1, 1'b0, 16'h0006, 16'h0000, 1'b0, 1'b0, 4'b0000, 16'h0606);
    idle_n(4);
    req(1'b1, 1'b0, 16'hFFFE, 16'h0000, 1'b0, 1'b0, 4'b0000, 16'hC0DE);
    idle_n(6);

    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: %0d reads still pending, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
